// File: rtl/i2c_ack_stop.sv
// I2C master ACK-clock / STOP stage: clocks the ACK bit, samples the slave's ACK/NACK
// and optionally emits STOP. Optional clock stretching in ACK_HIGH via I2C_ACK_STRETCH_EN.
module i2c_ack_stop #(
  parameter int CTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CTR_WIDTH-1:0] clock_divisor,
  input  logic                 start,
  input  logic                 last,
  input  logic                 sda_in,
  input  logic                 scl_in,
  output logic                 scl_out,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 nack
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ACK_LOW   = 4'd1,
    ACK_HIGH  = 4'd2,
    STOP_LOW  = 4'd3,
    STOP_HIGH = 4'd4,
    STOP_REL  = 4'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic [CTR_WIDTH-1:0] div_q, div_d;
  logic                 last_q, last_d;
  logic                 nack_q, nack_d;
  logic                 done_q, done_d;
  logic                 stall;

`ifdef I2C_ACK_STRETCH_EN
  // Slave holding SCL low keeps the ACK-high phase pinned at its first cycle.
  assign stall = (state_q == ACK_HIGH) && !scl_in;
`else
  logic unused_scl_in;
  assign stall         = 1'b0;
  assign unused_scl_in = scl_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      div_q   <= '0;
      last_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      div_q   <= div_d;
      last_q  <= last_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    div_d   = div_q;
    last_d  = last_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        div_d   = clock_divisor;
        last_d  = last;
        ctr_d   = '0;
        state_d = ACK_LOW;
      end
    end else if (stall) begin
      ctr_d = '0;
    end else if (ctr_q == div_q) begin
      ctr_d = '0;
      case (state_q)
        ACK_LOW:   state_d = ACK_HIGH;
        ACK_HIGH: begin
          nack_d = sda_in;
          if (sda_in || last_q) begin
            state_d = STOP_LOW;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        STOP_LOW:  state_d = STOP_HIGH;
        STOP_HIGH: state_d = STOP_REL;
        STOP_REL: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default:   state_d = IDLE;
      endcase
    end else begin
      ctr_d = ctr_q + 1'b1;
    end
  end

  always_comb begin
    scl_out = 1'b1;
    sda_oe  = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      ACK_LOW:   scl_out = 1'b0;
      STOP_LOW: begin
        scl_out = 1'b0;
        sda_oe  = 1'b1;
      end
      STOP_HIGH: sda_oe = 1'b1;
      default: ;
    endcase
  end

  assign done = done_q;
  assign nack = nack_q;

endmodule

// File: tb/tb_i2c_ack_stop.sv
// Bench for i2c_ack_stop: timeline model checked every cycle plus directed literal checks.
module tb_i2c_ack_stop;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] clock_divisor;
  logic        start, last, sda_in, scl_in;
  logic        scl_out, sda_oe, busy, done, nack;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  i2c_ack_stop #(.CTR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clock_divisor(clock_divisor), .start(start),
    .last(last), .sda_in(sda_in), .scl_in(scl_in), .scl_out(scl_out),
    .sda_oe(sda_oe), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position m_n = edges since the accepted start; phases are D+1 long.
  int m_n, m_d;
  bit m_active = 1'b0, m_last, m_nack = 1'b0, m_done = 1'b0, m_hold;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_nack   = 1'b0;
    end else if (m_active) begin
      m_hold = 1'b0;
`ifdef I2C_ACK_STRETCH_EN
      m_hold = (m_n >= m_d + 1) && (m_n <= 2 * m_d + 1) && !scl_in;
`endif
      if (m_hold) m_n = m_d + 1;
      else        m_n = m_n + 1;
      if (!m_hold && m_n == 2 * m_d + 2) begin
        m_nack = sda_in;
        if (!(m_last || sda_in)) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (m_n == 5 * m_d + 5) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_n      = 0;
      m_d      = int'(clock_divisor);
      m_last   = last;
    end
  end

  always @(negedge clk) begin
    logic e_scl, e_oe;
    if (chk_en) begin
      e_scl = 1'b1;
      e_oe  = 1'b0;
      if (m_active) begin
        if      (m_n <= m_d)         e_scl = 1'b0;
        else if (m_n <= 2 * m_d + 1) e_scl = 1'b1;
        else if (m_n <= 3 * m_d + 2) begin e_scl = 1'b0; e_oe = 1'b1; end
        else if (m_n <= 4 * m_d + 3) e_oe = 1'b1;
      end
      chk("model_scl_out", 32'(scl_out), 32'(e_scl));
      chk("model_sda_oe",  32'(sda_oe),  32'(e_oe));
      chk("model_busy",    32'(busy),    32'(m_active));
      chk("model_done",    32'(done),    32'(m_done));
      if (!m_active) chk("model_nack", 32'(nack), 32'(m_nack));
    end
  end

  task automatic run_seq(input string name, input logic [15:0] d, input bit l, input bit sda_v,
                         input int stretch, input bit extra_start,
                         input int exp_done, input bit exp_nack, input int exp_oe);
    int cyc, oe;
    @(negedge clk);
    clock_divisor = d; last = l; sda_in = sda_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; oe = 0;
    while (!done && cyc < exp_done + 50) begin
      if (sda_oe) oe++;
      scl_in = !(cyc >= int'(d) + 1 && cyc < int'(d) + 1 + stretch);
      if (extra_start && cyc == 1) begin
        start = 1'b1; clock_divisor = 16'd0; last = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    scl_in = 1'b1; sda_in = 1'b0;
    chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_done));
    chk({name, "_nack"}, 32'(nack), 32'(exp_nack));
    chk({name, "_sda_oe_cycles"}, 32'(oe), 32'(exp_oe));
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    $display("txn %s: D=%0d last=%0b sda=%0b done_at=%0d nack=%0b oe_cycles=%0d",
             name, d, l, sda_v, cyc, nack, oe);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; last = 1'b0; sda_in = 1'b0; scl_in = 1'b1;
    clock_divisor = 16'd0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_scl_out", 32'(scl_out), 32'd1);
    chk("reset_sda_oe",  32'(sda_oe),  32'd0);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_nack",    32'(nack),    32'd0);
    rst_n = 1'b1;

    run_seq("ack_d3",      16'd3, 1'b0, 1'b0, 0, 1'b0, 8,  1'b0, 0);
    run_seq("stop_d3",     16'd3, 1'b1, 1'b0, 0, 1'b0, 20, 1'b0, 8);
    run_seq("nack_d2",     16'd2, 1'b0, 1'b1, 0, 1'b0, 15, 1'b1, 6);
    run_seq("ack_d0",      16'd0, 1'b0, 1'b0, 0, 1'b0, 2,  1'b0, 0);
    run_seq("stop_d0",     16'd0, 1'b1, 1'b0, 0, 1'b0, 5,  1'b0, 2);
    run_seq("dbl_start",   16'd3, 1'b0, 1'b0, 0, 1'b1, 8,  1'b0, 0);
`ifdef I2C_ACK_STRETCH_EN
    run_seq("stretch",     16'd3, 1'b0, 1'b0, 5, 1'b0, 13, 1'b0, 0);
`else
    run_seq("stretch",     16'd3, 1'b0, 1'b0, 5, 1'b0, 8,  1'b0, 0);
`endif

    // Reset in STOP_HIGH (positions 12..15 for D=3).
    @(negedge clk);
    clock_divisor = 16'd3; last = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_reset_sda_oe", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_scl_out", 32'(scl_out), 32'd1);
    chk("midreset_sda_oe",  32'(sda_oe),  32'd0);
    chk("midreset_busy",    32'(busy),    32'd0);
    chk("midreset_done",    32'(done),    32'd0);
    $display("txn midreset: reset applied in STOP_HIGH busy=%0b", busy);
    repeat (3) @(negedge clk);

    // Max divisor: ACK_LOW lasts 65536 cycles, then ctr reloads and SCL rises.
    clock_divisor = 16'hFFFF; last = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!scl_out && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    chk("maxdiv_ack_low_cycles", 32'(cyc), 32'd65536);
    chk("maxdiv_busy", 32'(busy), 32'd1);
    $display("txn maxdiv: D=ffff scl_out low for %0d cycles", cyc);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
